dma_ctrl: RTL
=============

Name: dma_ctrl

Overview:
- DMA peripheral directly downstream of the CPU's MMIO address decoder.
- Presents a small register file on the dma_mmio slave port.
- On start, copies LEN 32-bit words from SRC to DST through its own memory master port; the system arbitrates that port with CPU traffic to RAM.
- Reports completion via a status register and, optionally, an interrupt line.

Parameters:
- XLEN, 32, data/address width (taken from the shared XLEN define).
- LEN_W, 16, width of the transfer-length register in words; max transfer is 2^LEN_W-1 words.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- dma_mmio_req  input  1  CPU register access valid.
- dma_mmio_we  input  1  1 = write, 0 = read.
- dma_mmio_addr  input  XLEN  byte address; only bits [4:2] decode the register.
- dma_mmio_wdata  input  XLEN  register write data.
- dma_mmio_rdata  output  XLEN  register read data.
- dma_mmio_ready  output  1  access complete.
- dma_mem_req  output  1  master request valid.
- dma_mem_we  output  1  master write enable.
- dma_mem_addr  output  XLEN  master word address (bits [1:0] always 0).
- dma_mem_wdata  output  XLEN  master write data.
- dma_mem_rdata  input  XLEN  master read data, valid with ready on reads.
- dma_mem_ready  input  1  master access complete.
- dma_irq  output  1  level interrupt (DMA_IRQ_EN only; otherwise constant 0).

Behaviour:
- Register map (offset: name):
  - 0x00 SRC
  - 0x04 DST
  - 0x08 LEN
  - 0x0C CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN
  - 0x10 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C)
  - Other offsets read 0; writes to them are ignored.
- MMIO timing:
  - dma_mmio_ready = dma_mmio_req, combinational, zero wait.
  - dma_mmio_rdata is combinational from registers while req=1, else 0.
  - Writes commit on the clock edge where req&we=1.
- Writes to SRC/DST/LEN, and START, are ignored while BUSY. IRQ_EN and W1C bits remain writable while BUSY.
- START with SRC[1:0]!=0 or DST[1:0]!=0: ERR=1, DONE=1, no transfer, BUSY stays 0.
- START with LEN=0: DONE=1 on the next edge, no memory access.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE -> RD on valid START with LEN!=0. Working copies are loaded: cur_src=SRC, cur_dst=DST, remaining=LEN.
  - RD: req=1, we=0, addr=cur_src. On ready, capture rdata into the data buffer and go to WR.
  - WR: req=1, we=1, addr=cur_dst, wdata=buffer. On ready:
    - cur_src+=4 and cur_dst+=4, wrapping mod 2^XLEN.
    - remaining-=1.
    - If remaining becomes 0 go to FIN, else go to RD.
  - FIN: DONE=1, then go to IDLE (one cycle).
- BUSY=1 in RD, WR and FIN.
- Master signals are held stable from request assertion until ready is sampled high. dma_mem_req=0 in IDLE and FIN.
- Minimum cost is 2 cycles per word when ready is same-cycle.
- SRC/DST/LEN architectural registers are not modified by the transfer.
- Simultaneous events:
  - A W1C of DONE in the same cycle that FIN sets DONE: the set wins.
  - START together with a CTRL write: IRQ_EN updates in the same edge.
- Reset (any time, including mid-transfer):
  - All registers and STATUS are cleared; FSM returns to IDLE.
  - dma_mem_req=0 and dma_irq=0 from the cycle after the reset edge.
  - dma_mmio_rdata=0 while no request.

Optional Feature:
- DMA_IRQ_EN defined: dma_irq = IRQ_EN & (DONE | ERR), registered, so it tracks STATUS with zero extra latency after the edge.
- DMA_IRQ_EN undefined: dma_irq is tied to 0, the CTRL bit1 storage is removed, and CTRL bit1 reads 0.

Decomposition:
- Shared defines.vh holds:
  - the DMA register offsets (DMA_REG_SRC/DST/LEN/CTRL/STATUS);
  - CTRL/STATUS bit positions;
  - the FSM state encodings;
  - the existing XLEN and DMA address mask/match constants.
- Port lists use the existing MMIO/MEM port macros.
- One natural sub-module: dma_copy_fsm. It owns the working copies, the data buffer and the master port. Its interface is start/src/dst/len in and busy/done_pulse out. dma_ctrl keeps the register file and irq.

Test Plan:
- Reset, then read all five offsets plus 0x14 -> all return 0, ready=1 on same cycle, dma_mem_req=0.
- SRC=0x100, DST=0x200, LEN=3, START, memory always ready -> reads 0x100/0x104/0x108 each followed by a write to 0x200/0x204/0x208 with matching data; DONE=1 after 7 cycles (6 + FIN); BUSY low afterwards.
- Same transfer with ready delayed 3 cycles per access -> addr/we/wdata stable while waiting; data copied correctly; no duplicate accesses.
- LEN=0 START -> DONE=1 next cycle, zero master requests; SRC=0x102 START -> ERR=1, DONE=1, no requests; W1C 0x6 to STATUS clears both.
- While BUSY, write LEN=9 and issue START -> ignored, transfer finishes original length; DONE W1C coinciding with FIN leaves DONE=1.
- DMA_IRQ_EN build: IRQ_EN=1 -> dma_irq rises with DONE and falls after W1C. Assert rst mid-WR -> req drops next cycle, STATUS=0, a new transfer then runs cleanly.

Source files
------------

// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl_pkg: shared constants and types for the DMA controller.
// Register offsets (word index, byte address bits [4:2]), CTRL/STATUS bit
// positions, data width and the copy-engine state encoding.
package dma_ctrl_pkg;

   localparam int XLEN      = 32;
   localparam int DMA_LEN_W = 16;

   // Register word index taken from byte address bits [4:2]
   localparam logic [2:0] DMA_REG_SRC    = 3'd0;  // 0x00
   localparam logic [2:0] DMA_REG_DST    = 3'd1;  // 0x04
   localparam logic [2:0] DMA_REG_LEN    = 3'd2;  // 0x08
   localparam logic [2:0] DMA_REG_CTRL   = 3'd3;  // 0x0C
   localparam logic [2:0] DMA_REG_STATUS = 3'd4;  // 0x10

   // CTRL bits
   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;

   // STATUS bits
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   // Copy engine states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_FIN  = 2'd3
   } dma_state_e;

endpackage

// File: rtl/dma_copy_fsm.sv
// dma_copy_fsm: word-copy engine behind the DMA register file.
// Owns the working address/length copies, the one-word data buffer and the
// memory master port. Each word costs one read then one write; the master
// signals are pure functions of registered state, so they stay stable while
// waiting for ready.
module dma_copy_fsm
   import dma_ctrl_pkg::*;
#(
   parameter int LEN_W = DMA_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [XLEN-1:0]  src,
   input  logic [XLEN-1:0]  dst,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done_pulse,
   output logic             dma_mem_req,
   output logic             dma_mem_we,
   output logic [XLEN-1:0]  dma_mem_addr,
   output logic [XLEN-1:0]  dma_mem_wdata,
   input  logic [XLEN-1:0]  dma_mem_rdata,
   input  logic             dma_mem_ready
);

   dma_state_e       state, state_next;
   logic [XLEN-1:0]  cur_src, cur_dst, data_buf;
   logic [LEN_W-1:0] remaining;

   // State register with synchronous reset.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Working copies and data buffer: load on start, advance on each handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
         data_buf  <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               cur_src   <= src;
               cur_dst   <= dst;
               remaining <= len;
            end
            S_RD: if (dma_mem_ready) data_buf <= dma_mem_rdata;
            S_WR: if (dma_mem_ready) begin
               cur_src   <= cur_src + XLEN'(4);
               cur_dst   <= cur_dst + XLEN'(4);
               remaining <= remaining - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Next state and master-port outputs.
   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      state_next    = state;
      busy          = 1'b1;
      done_pulse    = 1'b0;
      dma_mem_req   = 1'b0;
      dma_mem_we    = 1'b0;
      dma_mem_addr  = cur_src;
      dma_mem_wdata = data_buf;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_next = S_RD;
         end
         S_RD: begin
            dma_mem_req = 1'b1;
            if (dma_mem_ready) state_next = S_WR;
         end
         S_WR: begin
            dma_mem_req  = 1'b1;
            dma_mem_we   = 1'b1;
            dma_mem_addr = cur_dst;
            if (dma_mem_ready)
               state_next = (remaining == LEN_W'(1)) ? S_FIN : S_RD;
         end
         S_FIN: begin
            done_pulse = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: MMIO-programmed word-copy DMA.
// Register file (SRC, DST, LEN, CTRL, STATUS) on a zero-wait MMIO slave port,
// copy engine in dma_copy_fsm. Optional interrupt output built only when the
// macro DMA_IRQ_EN is defined; otherwise dma_irq is 0 and CTRL.IRQ_EN reads 0.
module dma_ctrl
   import dma_ctrl_pkg::*;
#(
   parameter int LEN_W = DMA_LEN_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            dma_mmio_req,
   input  logic            dma_mmio_we,
   input  logic [XLEN-1:0] dma_mmio_addr,
   input  logic [XLEN-1:0] dma_mmio_wdata,
   output logic [XLEN-1:0] dma_mmio_rdata,
   output logic            dma_mmio_ready,
   output logic            dma_mem_req,
   output logic            dma_mem_we,
   output logic [XLEN-1:0] dma_mem_addr,
   output logic [XLEN-1:0] dma_mem_wdata,
   input  logic [XLEN-1:0] dma_mem_rdata,
   input  logic            dma_mem_ready,
   output logic            dma_irq
);

   logic [XLEN-1:0]  src_q, dst_q;
   logic [LEN_W-1:0] len_q;
   logic             done_q, err_q, done_next, err_next;
   logic             busy, done_pulse, irq_en_rd;
   logic [2:0]       reg_sel;
   logic             wr, wr_ctrl, wr_status, start_req, misaligned, fsm_start;
   logic             unused_addr_bits;

   assign reg_sel          = dma_mmio_addr[4:2];
   assign unused_addr_bits = ^{dma_mmio_addr[XLEN-1:5], dma_mmio_addr[1:0]};
   assign dma_mmio_ready   = dma_mmio_req;

   assign wr         = dma_mmio_req & dma_mmio_we;
   assign wr_ctrl    = wr && (reg_sel == DMA_REG_CTRL);
   assign wr_status  = wr && (reg_sel == DMA_REG_STATUS);
   assign start_req  = wr_ctrl & dma_mmio_wdata[CTRL_START] & ~busy;
   assign misaligned = (|src_q[1:0]) | (|dst_q[1:0]);
   assign fsm_start  = start_req & ~misaligned & (len_q != '0);

   // Sticky status next-state: W1C first, then sets, so a set wins a collision.
   always_comb begin
      done_next = done_q;
      err_next  = err_q;
      if (wr_status && dma_mmio_wdata[STAT_DONE]) done_next = 1'b0;
      if (wr_status && dma_mmio_wdata[STAT_ERR])  err_next  = 1'b0;
      if (start_req && misaligned) begin
         err_next  = 1'b1;
         done_next = 1'b1;
      end else if (start_req && (len_q == '0)) begin
         done_next = 1'b1;
      end
      if (done_pulse) done_next = 1'b1;
   end

   // Architectural registers (frozen while busy) and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (wr && !busy && reg_sel == DMA_REG_SRC) src_q <= dma_mmio_wdata;
         if (wr && !busy && reg_sel == DMA_REG_DST) dst_q <= dma_mmio_wdata;
         if (wr && !busy && reg_sel == DMA_REG_LEN) len_q <= dma_mmio_wdata[LEN_W-1:0];
         done_q <= done_next;
         err_q  <= err_next;
      end
   end

`ifdef DMA_IRQ_EN
   logic irq_en_q, irq_en_next, irq_q;

   assign irq_en_next = wr_ctrl ? dma_mmio_wdata[CTRL_IRQ_EN] : irq_en_q;

   // Interrupt enable and level irq, registered from next-state so it moves with STATUS.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_next;
         irq_q    <= irq_en_next & (done_next | err_next);
      end
   end

   assign irq_en_rd = irq_en_q;
   assign dma_irq   = irq_q;
`else
   assign irq_en_rd = 1'b0;
   assign dma_irq   = 1'b0;
`endif

   // Combinational read mux; drives 0 when no access is in progress.
   always_comb begin
      dma_mmio_rdata = '0;
      if (dma_mmio_req) begin
         case (reg_sel)
            DMA_REG_SRC:    dma_mmio_rdata = src_q;
            DMA_REG_DST:    dma_mmio_rdata = dst_q;
            DMA_REG_LEN:    dma_mmio_rdata = {{(XLEN-LEN_W){1'b0}}, len_q};
            DMA_REG_CTRL:   dma_mmio_rdata = {{(XLEN-2){1'b0}}, irq_en_rd, 1'b0};
            DMA_REG_STATUS: dma_mmio_rdata = {{(XLEN-3){1'b0}}, err_q, done_q, busy};
            default:        dma_mmio_rdata = '0;
         endcase
      end
   end

   dma_copy_fsm #(.LEN_W(LEN_W)) u_copy (
      .clk           (clk),
      .rst           (rst),
      .start         (fsm_start),
      .src           (src_q),
      .dst           (dst_q),
      .len           (len_q),
      .busy          (busy),
      .done_pulse    (done_pulse),
      .dma_mem_req   (dma_mem_req),
      .dma_mem_we    (dma_mem_we),
      .dma_mem_addr  (dma_mem_addr),
      .dma_mem_wdata (dma_mem_wdata),
      .dma_mem_rdata (dma_mem_rdata),
      .dma_mem_ready (dma_mem_ready)
   );

endmodule
